ad_serial_model: RTL



---
 rtl/ad_serial_pkg.sv | 20 ++
 rtl/ad_edge_sync.sv | 42 ++++
 rtl/ad_serial_model.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ad_serial_pkg.sv
// Shared types and constants for the multi-channel serial ADC model.
// Holds the FSM state type, Galois LFSR taps and the frame-width helper.
package ad_serial_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StShift
   } ad_state_e;

   // Maximal-length Galois taps (right-shifting form), indexed by sample width.
   localparam logic [15:0] LfsrTaps [8:16] = '{
      16'h00B8, 16'h0110, 16'h0240, 16'h0500, 16'h0E08,
      16'h1C80, 16'h3802, 16'h6000, 16'hB400
   };

   function automatic int unsigned frame_w(int unsigned lead, int unsigned data);
      return lead + data;
   endfunction

endpackage

// File: rtl/ad_edge_sync.sv
// Two-flop synchroniser for an asynchronous pin followed by a registered
// edge detector producing one-cycle rise/fall pulses.
module ad_edge_sync #(
   parameter logic RstVal = 1'b1
) (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic [1:0] sync_q, sync_d;
   logic       last_q, last_d;
   logic       rise_q, rise_d;
   logic       fall_q, fall_d;

   always_comb begin
      sync_d = {sync_q[0], d_i};
      last_d = sync_q[1];
      rise_d = sync_q[1] & ~last_q;
      fall_d = ~sync_q[1] & last_q;
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         sync_q <= {2{RstVal}};
         last_q <= RstVal;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         last_q <= last_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/ad_serial_model.sv
// Clocked model of CH_NUM serial ADCs sharing cs_n/sclk, one sdata line each.
// Define AD_SERIAL_LFSR_EN to replace the additive STEP update with a Galois LFSR.
module ad_serial_model
   import ad_serial_pkg::*;
#(
   parameter int unsigned          CH_NUM = 2,
   parameter int unsigned          DATA_W = 12,
   parameter int unsigned          LEAD_W = 2,
   parameter logic [DATA_W-1:0]    INIT   = 12'h523,
   parameter logic [DATA_W-1:0]    CH_OFS = 12'h100,
   parameter logic [DATA_W-1:0]    STEP   = 12'h111,
   parameter int unsigned          CNT_W  = 16
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   input  logic              cs_n,
   input  logic              sclk,
   output logic [CH_NUM-1:0] sdata,
   output logic [CNT_W-1:0]  conv_cnt,
   output logic              frame_err
);

   localparam int unsigned FrameW = frame_w(LEAD_W, DATA_W);
   localparam int unsigned BitW   = $clog2(FrameW + 1);

   function automatic logic [DATA_W-1:0] seed_of(int unsigned ch);
      logic [DATA_W-1:0] s;
      s = INIT + CH_OFS * DATA_W'(ch);
`ifdef AD_SERIAL_LFSR_EN
      if (s == '0) s = DATA_W'(1);
`endif
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] next_sample(logic [DATA_W-1:0] x);
`ifdef AD_SERIAL_LFSR_EN
      logic [15:0] taps;
      taps = LfsrTaps[DATA_W];
      return x[0] ? ((x >> 1) ^ taps[DATA_W-1:0]) : (x >> 1);
`else
      return x + STEP;
`endif
   endfunction

   logic cs_rise, cs_fall, sclk_fall, sclk_rise_unused;

   ad_edge_sync #(.RstVal(1'b1)) u_cs_sync (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .d_i     (cs_n),
      .rise_o  (cs_rise),
      .fall_o  (cs_fall)
   );

   ad_edge_sync #(.RstVal(1'b1)) u_sclk_sync (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .d_i     (sclk),
      .rise_o  (sclk_rise_unused),
      .fall_o  (sclk_fall)
   );

   ad_state_e         state_q, state_d;
   logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [FrameW-1:0] shift_q [CH_NUM];
   logic [FrameW-1:0] shift_d [CH_NUM];
   logic [DATA_W-1:0] data_q  [CH_NUM];
   logic [DATA_W-1:0] data_d  [CH_NUM];
   logic [CNT_W-1:0]  conv_cnt_q, conv_cnt_d;
   logic              frame_err_q, frame_err_d;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      data_d      = data_q;
      conv_cnt_d  = conv_cnt_q;
      frame_err_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cs_fall) begin
               for (int unsigned c = 0; c < CH_NUM; c++) shift_d[c] = FrameW'(data_q[c]);
               bit_cnt_d = '0;
               state_d   = StShift;
            end
         end
         StShift: begin
            // A close in the same cycle as a shift wins and suppresses the shift.
            if (cs_rise) begin
               for (int unsigned c = 0; c < CH_NUM; c++) data_d[c] = next_sample(data_q[c]);
               conv_cnt_d  = conv_cnt_q + CNT_W'(1);
               frame_err_d = (bit_cnt_q < BitW'(FrameW - 1));
               state_d     = StIdle;
            end else if (sclk_fall) begin
               for (int unsigned c = 0; c < CH_NUM; c++) shift_d[c] = shift_q[c] << 1;
               if (bit_cnt_q != BitW'(FrameW)) bit_cnt_d = bit_cnt_q + BitW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         conv_cnt_q  <= '0;
         frame_err_q <= 1'b0;
         for (int unsigned c = 0; c < CH_NUM; c++) begin
            shift_q[c] <= '0;
            data_q[c]  <= seed_of(c);
         end
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         conv_cnt_q  <= conv_cnt_d;
         frame_err_q <= frame_err_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
      end
   end

   always_comb begin
      sdata = '0;
      for (int unsigned c = 0; c < CH_NUM; c++) begin
         sdata[c] = (state_q == StShift) ? shift_q[c][FrameW-1] : 1'b0;
      end
   end

   assign conv_cnt  = conv_cnt_q;
   assign frame_err = frame_err_q;

endmodule
